// File: rtl/riscv_boot_ctrl_pkg.sv
// Shared definitions for the RISC-V boot controller.
//   state_e           : sequencer state encoding (HDR=0, LOAD=1, HOLD=2, RUN=3, DONE=4)
//   HALT_INSN_DEFAULT : instruction whose retirement ends the run (ecall)
package riscv_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/riscv_boot_ctrl_byte_packer.sv
// byte_packer: assembles XLEN-bit words from a byte stream, little-endian
// (first byte lands in bits [7:0]).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous clear of partial word and byte count
//   byte_in      : incoming byte
//   accept       : byte_in is consumed this cycle
//   word         : assembled word, valid together with word_valid
//   word_valid   : combinational; high in the cycle the last byte of a word is accepted
module byte_packer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [7:0]      byte_in,
  input  logic            accept,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);

  localparam int NB = XLEN / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [XLEN-1:0] buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Shift right and insert at the top: after NB bytes the first byte has
  // walked down to bits [7:0]. The word is presented combinationally so the
  // consumer can register it in the same edge that accepts the last byte.
  assign word       = (buf_q >> 8) | (XLEN'(byte_in) << (XLEN - 8));
  assign word_valid = accept && (cnt_q == CW'(NB - 1));

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clear) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      buf_d = word;
      cnt_d = word_valid ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl: streams a program image into instruction memory, holds the
// core in reset while loading, releases it, and ends the run on a halt
// instruction or when the cycle budget is exhausted.
// Image format: one header word N (word count), then N little-endian words.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready     : byte input handshake
//   restart                       : in DONE, clear status and wait for a new header
//   imem_we/imem_addr/imem_wdata  : registered instruction-memory write port
//   core_rst                      : core reset, high except in RUN
//   retire_valid/retire_insn      : retirement feed from the core
//   done/timed_out/bad_len        : registered, level-held run status
//   cycles/retired                : saturating RUN counters, frozen in DONE
//   dbg_state                     : current sequencer state (state_e encoding)
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
// rx_ready depends only on state, and upstream holds rx_data stable with
// rx_valid high until the transfer happens.
module riscv_boot_ctrl
  import riscv_boot_ctrl_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_AW    = 10,
  parameter int              RST_HOLD   = 2,
  parameter int              MAX_CYCLES = 1000,
  parameter logic [XLEN-1:0] HALT_INSN  = XLEN'(HALT_INSN_DEFAULT),
  parameter int              CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               restart,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               core_rst,
  input  logic               retire_valid,
  input  logic [XLEN-1:0]    retire_insn,
  output logic               done,
  output logic               timed_out,
  output logic               bad_len,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   retired,
  output logic [2:0]         dbg_state
);

  localparam int              LEN_W      = IMEM_AW + 1;
  localparam int              HOLD_W     = $clog2(RST_HOLD + 1) + 1;
  localparam logic [XLEN-1:0] MAX_LEN    = XLEN'(1) << IMEM_AW;
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic               bad_len_q, bad_len_d;
  logic               core_rst_q, core_rst_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;

  logic               accept;
  logic               packer_clear;
  logic [XLEN-1:0]    word;
  logic               word_valid;
  logic               halt_hit;

  assign rx_ready = (state_q == ST_HDR) || (state_q == ST_LOAD);
  assign accept   = rx_valid && rx_ready;
  assign halt_hit = retire_valid && (retire_insn == HALT_INSN);

  byte_packer #(.XLEN(XLEN)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .byte_in    (rx_data),
    .accept     (accept),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    hold_d       = hold_q;
    cycles_d     = cycles_q;
    retired_d    = retired_q;
    done_d       = done_q;
    timed_out_d  = timed_out_q;
    bad_len_d    = bad_len_q;
    core_rst_d   = core_rst_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    packer_clear = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (word_valid) begin
          // Full-width compare so high garbage bits cannot alias to a legal length.
          if ((word == '0) || (word > MAX_LEN)) begin
            bad_len_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            len_d   = word[LEN_W-1:0];
            wcnt_d  = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wcnt_q[IMEM_AW-1:0];
          imem_wdata_d = word;
          wcnt_d       = wcnt_q + LEN_W'(1);
          if ((wcnt_q + LEN_W'(1)) == len_q) begin
            hold_d  = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // HOLD is entered in the cycle the last write strobe is high, so
        // leaving at hold_q==RST_HOLD drops core_rst RST_HOLD+1 cycles later.
        if (hold_q == HOLD_W'(RST_HOLD)) begin
          core_rst_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
        if (retire_valid && (retired_q != '1)) retired_d = retired_q + CNT_W'(1);
        // Halt is checked first so it wins a tie with the budget.
        if (halt_hit) begin
          done_d     = 1'b1;
          core_rst_d = 1'b1;
          state_d    = ST_DONE;
        end else if (cycles_q == LAST_CYCLE) begin
          timed_out_d = 1'b1;
          core_rst_d  = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (restart) begin
          done_d       = 1'b0;
          timed_out_d  = 1'b0;
          bad_len_d    = 1'b0;
          cycles_d     = '0;
          retired_d    = '0;
          wcnt_d       = '0;
          packer_clear = 1'b1;
          state_d      = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HDR;
      len_q        <= '0;
      wcnt_q       <= '0;
      hold_q       <= '0;
      cycles_q     <= '0;
      retired_q    <= '0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      bad_len_q    <= 1'b0;
      core_rst_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      hold_q       <= hold_d;
      cycles_q     <= cycles_d;
      retired_q    <= retired_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      bad_len_q    <= bad_len_d;
      core_rst_q   <= core_rst_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign bad_len    = bad_len_q;
  assign cycles     = cycles_q;
  assign retired    = retired_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Testbench for riscv_boot_ctrl: table of load/run scenarios plus a
// randomly gapped load interrupted by an asynchronous reset.
module tb_riscv_boot_ctrl;

  localparam int          XLEN       = 32;
  localparam int          IMEM_AW    = 10;
  localparam int          RST_HOLD   = 2;
  localparam int          MAX_CYCLES = 48;
  localparam int          CNT_W      = 32;
  localparam logic [31:0] HALT       = 32'h0000_0073;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]         rx_data = '0;
  logic               rx_valid = 1'b0;
  logic               rx_ready;
  logic               restart = 1'b0;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_wdata;
  logic               core_rst;
  logic               retire_valid = 1'b0;
  logic [XLEN-1:0]    retire_insn = '0;
  logic               done, timed_out, bad_len;
  logic [CNT_W-1:0]   cycles, retired;
  logic [2:0]         dbg_state;

  riscv_boot_ctrl #(
    .XLEN(XLEN), .IMEM_AW(IMEM_AW), .RST_HOLD(RST_HOLD),
    .MAX_CYCLES(MAX_CYCLES), .HALT_INSN(HALT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .restart(restart),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .retire_valid(retire_valid), .retire_insn(retire_insn),
    .done(done), .timed_out(timed_out), .bad_len(bad_len),
    .cycles(cycles), .retired(retired),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_cyc = 0;
  bit gap_en = 1'b0;
  logic [IMEM_AW+XLEN-1:0] exp_q[$];
  logic [31:0] prog [3] = '{32'h0050_0093, 32'h0010_0113, 32'h0000_0073};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: instruction-memory writes ----------------
  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      we_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL imem_unexpected act=%0h:%0h exp=none", imem_addr, imem_wdata);
      end else begin
        chk("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = gap_en ? $urandom_range(0, 2) : 0;
    rx_valid = 1'b0;
    repeat (g) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (rx_ready) begin
        tick();
        rx_valid = 1'b0;
        return;
      end
      tick();
    end
    rx_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL byte_accept act=not_ready exp=ready");
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] word_of(input int vi, input int i);
    if (vi == 0 && i < 3) return prog[i];
    return {vi[7:0], 8'h5A, i[15:0]};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_bad_len"}, bad_len, 0);
    chk({tag, "_cycles"}, cycles, 0);
    chk({tag, "_retired"}, retired, 0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_done", done, 0);
    chk("restart_timed_out", timed_out, 0);
    chk("restart_bad_len", bad_len, 0);
    chk("restart_cycles", cycles, 0);
    chk("restart_retired", retired, 0);
    chk("restart_rx_ready", rx_ready, 1);
    chk("restart_core_rst", core_rst, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] n;
    int          halt_at;   // RUN cycle (1-based) retiring HALT; 0 = never
    int          every;     // non-halt retire every k RUN cycles; 0 = never
    logic        exp_bad;
    logic        exp_done;
    logic        exp_to;
    int          exp_cycles;
    int          exp_retired;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int vi);
    int  t0;
    bit  ended;
    t0 = cyc;
    send_word(v.n);
    if (v.exp_bad) begin
      chk("bad_len_rise", bad_len, 1);
      chk("bad_done", done, 0);
      chk("bad_core_rst", core_rst, 1);
      repeat (3) tick();
      chk("bad_len_hold", bad_len, 1);
      chk("bad_timed_out", timed_out, 0);
      chk("bad_core_rst_hold", core_rst, 1);
      chk("bad_rx_ready", rx_ready, 0);
      return;
    end
    for (int i = 0; i < int'(v.n); i++) begin
      exp_q.push_back({IMEM_AW'(i), word_of(vi, i)});
      send_word(word_of(vi, i));
    end
    if (!gap_en) chk("load_rate", cyc - t0, 4 * (int'(v.n) + 1));

    ended = 1'b0;
    for (int t = 0; t < RST_HOLD + 20; t++) begin
      if (core_rst == 1'b0) begin
        ended = 1'b1;
        break;
      end
      tick();
    end
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL core_rst_release act=high exp=low");
      return;
    end
    chk("rst_release_latency", cyc - we_cyc, RST_HOLD + 1);

    // RUN: the current cycle is RUN cycle 1. restart in RUN must be ignored.
    ended = 1'b0;
    for (int k = 1; k <= MAX_CYCLES + 5; k++) begin
      retire_valid = (k == v.halt_at) || (v.every != 0 && (k % v.every) == 0);
      retire_insn  = (k == v.halt_at) ? HALT : NOP;
      restart      = (k == 2);
      tick();
      if (done || timed_out) begin
        ended = 1'b1;
        break;
      end
    end
    retire_valid = 1'b0;
    restart      = 1'b0;
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL run_end act=running exp=finished");
    end
    chk("run_done", done, v.exp_done);
    chk("run_timed_out", timed_out, v.exp_to);
    chk("run_cycles", cycles, v.exp_cycles);
    chk("run_retired", retired, v.exp_retired);
    chk("run_core_rst", core_rst, 1);

    // DONE freezes status even with retires still arriving.
    retire_valid = 1'b1;
    retire_insn  = HALT;
    repeat (3) tick();
    retire_valid = 1'b0;
    chk("frozen_cycles", cycles, v.exp_cycles);
    chk("frozen_retired", retired, v.exp_retired);
    chk("frozen_done", done, v.exp_done);
    chk("frozen_timed_out", timed_out, v.exp_to);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{32'd3,          40, 5, 1'b0, 1'b1, 1'b0, 40,  8};
    vecs[1] = '{32'd0,           0, 0, 1'b1, 1'b0, 1'b0,  0,  0};
    vecs[2] = '{32'd1025,        0, 0, 1'b1, 1'b0, 1'b0,  0,  0};
    vecs[3] = '{32'h0001_0003,   0, 0, 1'b1, 1'b0, 1'b0,  0,  0};
    vecs[4] = '{32'd2,           0, 1, 1'b0, 1'b0, 1'b1, 48, 48};
    vecs[5] = '{32'd1,          48, 0, 1'b0, 1'b1, 1'b0, 48,  1};
    vecs[6] = '{32'd1024,        1, 0, 1'b0, 1'b1, 1'b0,  1,  1};
    vecs[7] = '{32'd1,          47, 3, 1'b0, 1'b1, 1'b0, 47, 16};

    #1 rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("in_rst");
    rst = 1'b0;
    tick();
    check_reset_vals("post_rst");

    for (int vi = 0; vi < 8; vi++) begin
      if (vi > 0) do_restart();
      run_vec(vecs[vi], vi);
    end

    // Randomly gapped load, ignored restart in LOAD, then async reset mid-word.
    do_restart();
    gap_en = 1'b1;
    send_word(32'd4);
    exp_q.push_back({IMEM_AW'(0), 32'h1122_3344});
    send_word(32'h1122_3344);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midload_rst");
    chk("sb_drain", exp_q.size(), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    run_vec('{32'd2, 3, 0, 1'b0, 1'b1, 1'b0, 3, 1}, 9);
    gap_en = 1'b0;

    chk("sb_final", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
